// File: rtl/seq_subtractor.sv
// seq_subtractor: multi-cycle z = x - y - b_in.
// One CHUNK-bit slice is resolved per clock with the borrow carried in a
// register between slices, so the critical path is a CHUNK-bit subtract.
// Valid/ready handshakes on both the operand and the result side.
// WIDTH must be an exact multiple of CHUNK.
module seq_subtractor #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] z,
  output logic             b_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Operand registers shift right by one slice per RUN cycle, so the slice
  // being worked on always sits in the low CHUNK bits.
  logic [WIDTH-1:0] x_reg, y_reg;
  logic             x_msb_reg, y_msb_reg;
  logic             borrow_reg;
  logic [KW-1:0]    k_reg;
  logic             b_out_reg, ovf_reg;
  logic [CHUNK-1:0] z_slice_reg [N];

  logic             accept;
  logic             step;
  logic             last_slice;
  logic [CHUNK:0]   diff;

  assign accept     = (state_reg == IDLE) && in_valid;
  assign step       = (state_reg == RUN);
  assign last_slice = (k_reg == K_LAST);

  // One slice of subtraction, CHUNK+1 bits wide; the top bit is the borrow out.
  assign diff = {1'b0, x_reg[CHUNK-1:0]} - {1'b0, y_reg[CHUNK-1:0]}
              - {{CHUNK{1'b0}}, borrow_reg};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and handshake outputs derived from the registered state.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, slice sequencing, borrow chain and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg      <= '0;
      y_reg      <= '0;
      x_msb_reg  <= 1'b0;
      y_msb_reg  <= 1'b0;
      borrow_reg <= 1'b0;
      k_reg      <= '0;
      b_out_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (accept) begin
      x_reg      <= x;
      y_reg      <= y;
      x_msb_reg  <= x[WIDTH-1];
      y_msb_reg  <= y[WIDTH-1];
      borrow_reg <= b_in;
      k_reg      <= '0;
      b_out_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (step) begin
      x_reg      <= x_reg >> CHUNK;
      y_reg      <= y_reg >> CHUNK;
      borrow_reg <= diff[CHUNK];
      if (last_slice) begin
        k_reg     <= '0;
        b_out_reg <= diff[CHUNK];
        // Signed overflow: operands of differing sign and a result whose
        // sign differs from the minuend. diff[CHUNK-1] is the new z MSB.
        ovf_reg   <= (x_msb_reg != y_msb_reg) && (diff[CHUNK-1] != x_msb_reg);
      end else begin
        k_reg <= k_reg + KW'(1);
      end
    end
  end

  // Each result slice is owned by its own register and written only on the
  // RUN cycle whose slice index matches it.
  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    always_ff @(posedge clk) begin
      if (rst || accept)                     z_slice_reg[gi] <= '0;
      else if (step && (k_reg == KW'(gi)))   z_slice_reg[gi] <= diff[CHUNK-1:0];
    end
    assign z[gi*CHUNK +: CHUNK] = z_slice_reg[gi];
  end

  assign b_out = b_out_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench for seq_subtractor: directed vectors, randomized
// operands against an arithmetic reference model, backpressure, abort and
// back-to-back throughput.
module tb_seq_subtractor;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] x, y, z;
  logic        b_in, in_valid, in_ready, b_out, ovf, out_valid, out_ready;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;

  seq_subtractor #(.WIDTH(64), .CHUNK(16)) u_dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .b_out(b_out), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: full-width unsigned and signed arithmetic.
  function automatic void model(input logic [63:0] a, input logic [63:0] bb,
                                input logic bi, output logic [63:0] zz,
                                output logic bo, output logic oo);
    logic [64:0]        u;
    logic signed [65:0] sa, sb, s;
    u  = {1'b0, a} - {1'b0, bb} - {64'd0, bi};
    zz = u[63:0];
    bo = u[64];
    sa = $signed(a);
    sb = $signed(bb);
    s  = sa - sb - $signed({65'd0, bi});
    oo = (s > $signed({2'b00, 64'h7FFF_FFFF_FFFF_FFFF})) ||
         (s < $signed({2'b11, 64'h8000_0000_0000_0000}));
  endfunction

  // Drive one operation from IDLE; called at #1 after an edge. Returns the
  // result seen when out_valid rose, the latency in cycles and whether
  // in_ready stayed low while busy. Junk operands are thrown at the DUT
  // during RUN; out_ready wiggles before out_valid when finishing.
  task automatic issue(input logic [63:0] xi, input logic [63:0] yi,
                       input logic bi, input bit finish_hs,
                       output logic [63:0] zo, output logic bo,
                       output logic oo, output int lat, output bit busy_ok);
    x = xi; y = yi; b_in = bi; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    last_acc = cyc;
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 30) begin
      if (in_ready) busy_ok = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      x         = {$urandom, $urandom};
      y         = {$urandom, $urandom};
      b_in      = 1'($urandom_range(0, 1));
      out_ready = finish_hs ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    zo = z; bo = b_out; oo = ovf;
    if (finish_hs) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; x = 64'd5; y = 64'd3; b_in = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({in_ready, out_valid, b_out, ovf} !== 4'b1000 || z !== 64'd0) begin
        n_err++;
        $display("FAIL reset_%0d: got rdy=%b vld=%b z=%h bo=%b ovf=%b, expected rdy=1 vld=0 z=0 bo=0 ovf=0",
                 i, in_ready, out_valid, z, b_out, ovf);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_start: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [63:0] tx[4], ty[4], tz[4];
    logic        tb[4], tbo[4], tov[4];
    logic [63:0] gz;
    logic        gb, go;
    int          lat;
    bit          busy;
    tx[0] = 64'd5;                  ty[0] = 64'd3; tb[0] = 1'b0;
    tz[0] = 64'd2;                  tbo[0] = 1'b0; tov[0] = 1'b0;
    tx[1] = 64'd0;                  ty[1] = 64'd1; tb[1] = 1'b0;
    tz[1] = 64'hFFFF_FFFF_FFFF_FFFF; tbo[1] = 1'b1; tov[1] = 1'b0;
    tx[2] = 64'h8000_0000_0000_0000; ty[2] = 64'd1; tb[2] = 1'b0;
    tz[2] = 64'h7FFF_FFFF_FFFF_FFFF; tbo[2] = 1'b0; tov[2] = 1'b1;
    tx[3] = 64'h1_0000;             ty[3] = 64'd1; tb[3] = 1'b1;
    tz[3] = 64'hFFFE;               tbo[3] = 1'b0; tov[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(tx[i], ty[i], tb[i], 1'b1, gz, gb, go, lat, busy);
      n_cmp++;
      if (gz !== tz[i] || gb !== tbo[i] || go !== tov[i]) begin
        n_err++;
        $display("FAIL directed_%0d: got z=%h bo=%b ovf=%b, expected z=%h bo=%b ovf=%b",
                 i, gz, gb, go, tz[i], tbo[i], tov[i]);
      end
      n_cmp++;
      if (lat !== N || !busy) begin
        n_err++;
        $display("FAIL directed_latency_%0d: got lat=%0d busy_ok=%0d, expected lat=%0d busy_ok=1",
                 i, lat, busy, N);
      end
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL directed_release_%0d: got rdy=%b vld=%b, expected rdy=1 vld=0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, bb, gz, ez;
    logic        bi, gb, go, eb, eo;
    int          lat;
    bit          busy;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = {$urandom, $urandom}; bb = {$urandom, $urandom}; end
        1: begin a = 64'($urandom_range(0, 300)); bb = 64'($urandom_range(0, 300)); end
        2: begin a = {$urandom, $urandom}; bb = a; end
        default: begin
          a  = {1'($urandom_range(0, 1)), 47'd0, 16'($urandom)} ^ 64'h7FFF_FFFF_FFFF_0000;
          bb = {1'($urandom_range(0, 1)), 47'd0, 16'($urandom)};
        end
      endcase
      bi = 1'($urandom_range(0, 1));
      model(a, bb, bi, ez, eb, eo);
      issue(a, bb, bi, 1'b1, gz, gb, go, lat, busy);
      n_cmp++;
      if (gz !== ez || gb !== eb || go !== eo || lat !== N || !busy) begin
        n_err++;
        $display("FAIL random_%0d: x=%h y=%h bi=%b got z=%h bo=%b ovf=%b lat=%0d, expected z=%h bo=%b ovf=%b lat=%0d",
                 i, a, bb, bi, gz, gb, go, lat, ez, eb, eo, N);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, bb, gz, ez;
    logic        gb, go, eb, eo;
    int          lat, first;
    bit          busy;
    a = {$urandom, $urandom}; bb = {$urandom, $urandom};
    issue(a, bb, 1'b0, 1'b1, gz, gb, go, lat, busy);
    first = last_acc;
    a = 64'd100; bb = 64'd200;
    model(a, bb, 1'b1, ez, eb, eo);
    issue(a, bb, 1'b1, 1'b1, gz, gb, go, lat, busy);
    n_cmp++;
    if (last_acc - first !== N + 2) begin
      n_err++;
      $display("FAIL b2b_throughput: got %0d cycles between acceptances, expected %0d",
               last_acc - first, N + 2);
    end
    n_cmp++;
    if (gz !== ez || gb !== eb || go !== eo) begin
      n_err++;
      $display("FAIL b2b_result: got z=%h bo=%b ovf=%b, expected z=%h bo=%b ovf=%b",
               gz, gb, go, ez, eb, eo);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, bb, gz, ez;
    logic        gb, go, eb, eo;
    int          lat;
    bit          busy;
    a = {$urandom, $urandom}; bb = {$urandom, $urandom};
    model(a, bb, 1'b1, ez, eb, eo);
    issue(a, bb, 1'b1, 1'b0, gz, gb, go, lat, busy);
    n_cmp++;
    if (gz !== ez || gb !== eb || go !== eo) begin
      n_err++;
      $display("FAIL bp_result: got z=%h bo=%b ovf=%b, expected z=%h bo=%b ovf=%b",
               gz, gb, go, ez, eb, eo);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      x = {$urandom, $urandom}; y = {$urandom, $urandom}; b_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n_cmp++;
      if (z !== ez || b_out !== eb || ovf !== eo || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got z=%h bo=%b ovf=%b vld=%b rdy=%b, expected z=%h bo=%b ovf=%b vld=1 rdy=0",
                 i, z, b_out, ovf, out_valid, in_ready, ez, eb, eo);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
    end
    a = 64'h0000_0001_0000_0000; bb = 64'h0000_0000_0000_0001;
    model(a, bb, 1'b0, ez, eb, eo);
    issue(a, bb, 1'b0, 1'b1, gz, gb, go, lat, busy);
    n_cmp++;
    if (gz !== ez || gb !== eb || go !== eo || lat !== N) begin
      n_err++;
      $display("FAIL bp_next_op: got z=%h bo=%b ovf=%b lat=%0d, expected z=%h bo=%b ovf=%b lat=%0d",
               gz, gb, go, lat, ez, eb, eo, N);
    end
  endtask

  task automatic test_abort();
    logic [63:0] gz;
    logic        gb, go;
    int          lat;
    bit          busy;
    // Abort in RUN: accept at E0, rst sampled at E2.
    x = 64'd5; y = 64'd3; b_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, b_out, ovf} !== 4'b1000 || z !== 64'd0) begin
      n_err++;
      $display("FAIL abort_run: got rdy=%b vld=%b z=%h bo=%b ovf=%b, expected rdy=1 vld=0 z=0 bo=0 ovf=0",
               in_ready, out_valid, z, b_out, ovf);
    end
    repeat (N + 1) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_no_result: got vld=%b rdy=%b, expected vld=0 rdy=1", out_valid, in_ready);
    end
    // Abort in DONE with a result pending.
    issue(64'd0, 64'd1, 1'b0, 1'b0, gz, gb, go, lat, busy);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, b_out, ovf} !== 4'b1000 || z !== 64'd0) begin
      n_err++;
      $display("FAIL abort_done: got rdy=%b vld=%b z=%h bo=%b ovf=%b, expected rdy=1 vld=0 z=0 bo=0 ovf=0",
               in_ready, out_valid, z, b_out, ovf);
    end
    issue(64'd10, 64'd10, 1'b0, 1'b1, gz, gb, go, lat, busy);
    n_cmp++;
    if (gz !== 64'd0 || gb !== 1'b0 || go !== 1'b0 || lat !== N) begin
      n_err++;
      $display("FAIL abort_fresh: got z=%h bo=%b ovf=%b lat=%0d, expected z=0 bo=0 ovf=0 lat=%0d",
               gz, gb, go, lat, N);
    end
  endtask

  initial begin
    rst = 1'b1; x = '0; y = '0; b_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
